// File: rtl/mul_shift_add.sv
// Sequential shift-add unsigned multiplier with valid/ready request and response channels.
// Optional build macro MUL_SHIFT_ADD_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mul_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;

  logic [PW-1:0]    acc_sum_c;
  logic [WIDTH-1:0] mplier_shr_c;
  logic [CW-1:0]    cnt_inc_c;
  logic             last_c;

  // One shift-add step and the end-of-operation decision for the current BUSY cycle.
  always_comb begin
    acc_sum_c    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shr_c = mplier_q >> 1;
    cnt_inc_c    = cnt_q + CW'(1);
`ifdef MUL_SHIFT_ADD_EARLY_TERM_EN
    last_c = (cnt_inc_c == CW'(WIDTH)) || (mplier_shr_c == '0);
`else
    last_c = (cnt_inc_c == CW'(WIDTH));
`endif

    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake flags follow the next state so they are plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Datapath: capture on accept, iterate in BUSY, latch the product on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= PW'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          acc_q    <= acc_sum_c;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shr_c;
          cnt_q    <= cnt_inc_c;
          if (last_c) y <= acc_sum_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: directed vector table, reset corner case and a random soak.
module tb_mul_shift_add;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;

  int n_tests;
  int n_fail;
  int n_req;
  int n_resp;
  logic [2*W-1:0] last_y;

  mul_shift_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    int             stall;
    bit             poke_req;
    logic [2*W-1:0] exp_y;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Latency from the rules: fixed WIDTH, or position of b's top set bit when early exit is built in.
  function automatic int exp_lat(input logic [W-1:0] vb);
`ifdef MUL_SHIFT_ADD_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < int'(W); i++) if (vb[i]) h = i + 1;
    return (h == 0) ? 1 : h;
`else
    return int'(W);
`endif
  endfunction

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input int stall, input bit poke_req);
    logic [2*W-1:0] exp;
    int t;
    int lat;
    exp = (2*W)'(longint'(oa) * longint'(ob));
    @(negedge clk);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    n_req++;
    chk("in_ready_busy", longint'(in_ready), 0);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = ~oa;
    b         = W'($urandom);
    out_ready = 1'($urandom);
    // Count edges from accept until the product appears; y must hold the old result meanwhile.
    lat = 1;
    #5;
    #1;
    while (!out_valid && lat < 40) begin
      chk("y_hold_busy", longint'(y), longint'(last_y));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat(ob));
    chk("product", longint'(y), longint'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (poke_req) begin
        in_valid = 1'b1;
        a = 8'd1;
        b = 8'd1;
      end
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || y !== exp || in_ready !== 1'b0)
        chk("stall_hold", {out_valid, in_ready, y}, {1'b1, 1'b0, exp});
      else
        chk("stall_hold", longint'(y), longint'(exp));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_drop", longint'(out_valid), 0);
    chk("in_ready_rise", longint'(in_ready), 1);
    n_resp++;
    last_y = exp;
  endtask

  vec_t vecs[9];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_req     = 0;
    n_resp    = 0;
    last_y    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    rst_n     = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_y", longint'(y), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{8'd3,   8'd5,   0,  1'b0, 16'd15};
    vecs[1] = '{8'd255, 8'd255, 0,  1'b0, 16'd65025};
    vecs[2] = '{8'd0,   8'd200, 0,  1'b0, 16'd0};
    vecs[3] = '{8'd17,  8'd13,  20, 1'b1, 16'd221};
    vecs[4] = '{8'd10,  8'd10,  1,  1'b0, 16'd100};
    vecs[5] = '{8'd255, 8'd0,   0,  1'b0, 16'd0};
    vecs[6] = '{8'd1,   8'd128, 2,  1'b0, 16'd128};
    vecs[7] = '{8'd128, 8'd2,   0,  1'b0, 16'd256};
    vecs[8] = '{8'd200, 8'd1,   0,  1'b0, 16'd200};

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].stall, vecs[i].poke_req);
      chk("table_y", longint'(last_y), longint'(vecs[i].exp_y));
    end

    // Reset in the middle of BUSY, between clock edges, discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd9;
    b = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_y", longint'(y), 0);
    n_req++;
    n_resp++;
    last_y = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_out_valid", longint'(out_valid), 0);
    do_op(8'd6, 8'd7, 0, 1'b0);
    chk("postrst_y", longint'(last_y), 42);

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
    chk("resp_count", n_resp, n_req);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
